mopshub_hub_ctrl_32bus: RTL and testbench
=========================================

Name: mopshub_hub_ctrl_32bus

Overview:
Control and routing core of the 32-bus MOPSHUB.
- Sequences hub start-up: initialisation, per-bus power-up, optional per-bus oscillator trim, then sign-on.
- Arbitrates uplink CAN frames from up to 32 buses towards the elink side.
- Routes single downlink frames from the elink side to a selected bus.
- CAN controllers, elink serialisers, SPI and clock generation/division are external.

Parameters:
INIT_CYCLES, 16, cycles spent in INIT.
POWER_CYCLES, 8, cycles each bus is held in POWER before advancing.
TRIM_CYCLES, 32, cycles each bus is held in TRIM.
DATA_W, 76, CAN frame width (uplink and downlink).

Ports:
clk  in  1  single system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
n_buses  in  5  index of highest active bus (31 = all 32 buses).
osc_auto_trim_mopshub  in  1  enable per-bus trim during power-up; sampled on entry to each TRIM decision.
endwait_all  in  1  abort current wait (counter or pending uplink buffer).
rx_req  in  32  per-bus uplink frame available.
rx_data  in  DATA_W  frame of bus can_rec_select; external mux.
rx_ack  out  32  one-hot, 1-cycle capture acknowledge.
uplink_ack  in  1  elink side has consumed data_rec_uplink.
data_rec_uplink  out  DATA_W  captured uplink frame.
can_rec_select  out  5  uplink scan pointer / source bus of data_rec_uplink.
irq_elink_rec  out  1  1-cycle pulse: new uplink frame captured.
tx_valid  in  1  downlink frame offered.
tx_data  in  DATA_W  downlink frame.
tx_bus  in  5  downlink destination bus.
tx_ready  out  1  downlink frame can be accepted.
data_tra_downlink  out  DATA_W  latched downlink frame.
can_tra_select  out  5  latched destination bus.
tx_start  out  32  one-hot, 1-cycle start to destination bus.
tx_done  in  1  destination bus finished transmission.
irq_elink_tra  out  1  1-cycle pulse on downlink acceptance.
tx_err  out  1  1-cycle pulse: frame dropped, tx_bus > n_buses.
start_init, end_init  out  1  1-cycle pulses on INIT entry and exit.
power_bus_en  out  1  high during POWER/TRIM phase.
power_bus_cnt  out  5  bus currently being powered/trimmed.
start_trim_ack, end_trim_bus  out  1  1-cycle pulses on TRIM entry and exit.
end_power_init  out  1  1-cycle pulse after last bus completes.
sign_on_sig  out  1  1-cycle pulse, hub operational.
run  out  1  high in RUN.

Behaviour:
- Reset (asynchronous, any time): state IDLE; all outputs, counters, pointers and buffers = 0; pending transfers discarded.
- IDLE: first clock after reset release -> INIT.
- INIT:
  - start_init pulses on the entry cycle.
  - Stays INIT_CYCLES cycles, or exits the cycle endwait_all=1.
  - end_init pulses on the exit cycle; next state POWER with power_bus_cnt=0.
- POWER:
  - power_bus_en=1; hold POWER_CYCLES, or exit early on endwait_all.
  - Exit with osc_auto_trim_mopshub=1 -> TRIM.
  - Exit otherwise -> next bus.
- TRIM:
  - start_trim_ack pulses on entry; hold TRIM_CYCLES, or exit early on endwait_all.
  - end_trim_bus pulses on exit -> next bus.
- Next bus:
  - If power_bus_cnt < n_buses: increment, back to POWER.
  - Else: end_power_init pulse, power_bus_en=0, -> SIGNON.
- SIGNON: sign_on_sig pulses for 1 cycle -> RUN (run=1). RUN is terminal until reset.
- Uplink (RUN only):
  - can_rec_select advances by 1 every cycle while the buffer is empty and rx_req[ptr]=0; wraps from n_buses to 0.
  - If rx_req[ptr]=1 and buffer empty, in the same cycle: data_rec_uplink<=rx_data, rx_ack[ptr] pulse, irq_elink_rec pulse, buffer full. The pointer holds.
  - Buffer full: freeze pointer and data.
  - uplink_ack or endwait_all empties the buffer; scan resumes at ptr+1 next cycle.
  - rx_req bits above n_buses are ignored.
- Downlink (RUN only, concurrent with uplink):
  - tx_ready=1 when no transfer is pending.
  - tx_valid & tx_ready, tx_bus <= n_buses: latch data_tra_downlink and can_tra_select; pulse tx_start[tx_bus] and irq_elink_tra; tx_ready=0.
  - tx_done=1 while pending: tx_ready=1 the next cycle.
  - tx_valid & tx_ready, tx_bus > n_buses: tx_err pulse; nothing latched; tx_ready stays 1.
  - tx_valid outside RUN is ignored.
- Simultaneous events:
  - uplink_ack and a new rx_req in the same cycle: free the buffer this cycle, capture no earlier than the next cycle.
  - tx_done and tx_valid in the same cycle: the frame is not accepted (tx_ready was 0).

Test Plan:
- Reset, n_buses=3, trim=0, no endwait -> start_init at cycle 1, end_init at cycle 16; power_bus_cnt 0,1,2,3 each for 8 cycles; end_power_init then sign_on_sig on consecutive cycles; no trim pulses.
- n_buses=1, trim=1 -> per bus: POWER 8 cycles, start_trim_ack, TRIM 32 cycles, end_trim_bus; end_power_init after bus 1.
- RUN, n_buses=31, rx_req[5]=1, rx_data=76'hABC -> capture when can_rec_select=5; rx_ack=32'h20 and irq_elink_rec for 1 cycle; pointer holds until uplink_ack, then continues from 6.
- RUN, rx_req[2] and rx_req[30] both 1, pointer at 3 -> bus 30 served first, bus 2 after wrap; with n_buses=15, rx_req[30] is never served.
- RUN, tx_valid, tx_bus=4 -> can_tra_select=4, tx_start=32'h10, irq_elink_tra pulse, tx_ready=0 until 1 cycle after tx_done; tx_bus=20 with n_buses=15 -> tx_err pulse, nothing latched.
- Mid-INIT endwait_all=1 -> immediate end_init; rst asserted during RUN with buffer full -> all outputs 0 immediately, sequence restarts from INIT.

Source files
------------

// File: rtl/mopshub_hub_ctrl_32bus.sv
// Control and routing core of the 32-bus MOPSHUB.
// Start-up sequencing runs in this order: INIT, per-bus POWER, optional TRIM, then SIGN-ON.
// After start-up the hub stays in RUN until reset.
// In RUN, a round-robin scan captures one uplink CAN frame at a time into a single buffer.
// Also in RUN, single downlink frames are routed to a destination bus.
// Start-up pulses are decoded from the state and counter.
// Capture and route pulses are registered, so they line up with the latched data.
module mopshub_hub_ctrl_32bus #(
    parameter int INIT_CYCLES  = 16,
    parameter int POWER_CYCLES = 8,
    parameter int TRIM_CYCLES  = 32,
    parameter int DATA_W       = 76
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        n_buses,
    input  logic              osc_auto_trim_mopshub,
    input  logic              endwait_all,
    input  logic [31:0]       rx_req,
    input  logic [DATA_W-1:0] rx_data,
    output logic [31:0]       rx_ack,
    input  logic              uplink_ack,
    output logic [DATA_W-1:0] data_rec_uplink,
    output logic [4:0]        can_rec_select,
    output logic              irq_elink_rec,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [4:0]        tx_bus,
    output logic              tx_ready,
    output logic [DATA_W-1:0] data_tra_downlink,
    output logic [4:0]        can_tra_select,
    output logic [31:0]       tx_start,
    input  logic              tx_done,
    output logic              irq_elink_tra,
    output logic              tx_err,
    output logic              start_init,
    output logic              end_init,
    output logic              power_bus_en,
    output logic [4:0]        power_bus_cnt,
    output logic              start_trim_ack,
    output logic              end_trim_bus,
    output logic              end_power_init,
    output logic              sign_on_sig,
    output logic              run
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_POWER  = 3'd2;
    localparam logic [2:0] S_TRIM   = 3'd3;
    localparam logic [2:0] S_PDONE  = 3'd4;
    localparam logic [2:0] S_SIGNON = 3'd5;
    localparam logic [2:0] S_RUN    = 3'd6;

    logic [2:0] state;
    logic [7:0] cnt;
    logic       in_run;
    logic       init_done;
    logic       power_done;
    logic       trim_done;
    logic       last_bus;

    logic       up_full;
    logic       ptr_ok;
    logic [4:0] ptr_next;
    logic       capture;
    logic       release_buf;

    logic       tx_pend;
    logic       tx_offer;
    logic       tx_in_range;

    assign in_run     = (state == S_RUN);
    assign init_done  = (state == S_INIT)  && (endwait_all || cnt == 8'(INIT_CYCLES - 1));
    assign power_done = (state == S_POWER) && (endwait_all || cnt == 8'(POWER_CYCLES - 1));
    assign trim_done  = (state == S_TRIM)  && (endwait_all || cnt == 8'(TRIM_CYCLES - 1));
    assign last_bus   = (power_bus_cnt >= n_buses);

    assign start_init     = (state == S_INIT) && (cnt == 8'd0);
    assign end_init       = init_done;
    assign power_bus_en   = (state == S_POWER) || (state == S_TRIM);
    assign start_trim_ack = (state == S_TRIM) && (cnt == 8'd0);
    assign end_trim_bus   = trim_done;
    assign end_power_init = (state == S_PDONE);
    assign sign_on_sig    = (state == S_SIGNON);
    assign run            = in_run;

    // Start-up sequencer: phase state, per-phase cycle counter and the bus being powered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= 8'd0;
            power_bus_cnt <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_INIT;
                    cnt   <= 8'd0;
                end
                S_INIT: begin
                    if (init_done) begin
                        state         <= S_POWER;
                        cnt           <= 8'd0;
                        power_bus_cnt <= 5'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_POWER: begin
                    if (power_done) begin
                        cnt <= 8'd0;
                        if (osc_auto_trim_mopshub) begin
                            state <= S_TRIM;
                        end else if (last_bus) begin
                            state         <= S_PDONE;
                            power_bus_cnt <= 5'd0;
                        end else begin
                            power_bus_cnt <= power_bus_cnt + 5'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_TRIM: begin
                    if (trim_done) begin
                        cnt <= 8'd0;
                        if (last_bus) begin
                            state         <= S_PDONE;
                            power_bus_cnt <= 5'd0;
                        end else begin
                            state         <= S_POWER;
                            power_bus_cnt <= power_bus_cnt + 5'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_PDONE:  state <= S_SIGNON;
                S_SIGNON: state <= S_RUN;
                S_RUN:    state <= S_RUN;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // A pointer left above n_buses (n_buses lowered at run time) never captures and wraps to 0
    assign ptr_ok      = (can_rec_select <= n_buses);
    assign ptr_next    = (can_rec_select >= n_buses) ? 5'd0 : can_rec_select + 5'd1;
    assign capture     = in_run && !up_full && ptr_ok && rx_req[can_rec_select];
    assign release_buf = up_full && (uplink_ack || endwait_all);

    // Uplink scan: capture one frame, freeze until released, then resume after the served bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_full         <= 1'b0;
            can_rec_select  <= 5'd0;
            data_rec_uplink <= '0;
            rx_ack          <= 32'd0;
            irq_elink_rec   <= 1'b0;
        end else begin
            rx_ack        <= 32'd0;
            irq_elink_rec <= 1'b0;
            if (capture) begin
                data_rec_uplink <= rx_data;
                rx_ack          <= 32'd1 << can_rec_select;
                irq_elink_rec   <= 1'b1;
                up_full         <= 1'b1;
            end else if (release_buf) begin
                up_full        <= 1'b0;
                can_rec_select <= ptr_next;
            end else if (in_run && !up_full) begin
                can_rec_select <= ptr_next;
            end
        end
    end

    assign tx_ready    = in_run && !tx_pend;
    assign tx_offer    = tx_valid && tx_ready;
    assign tx_in_range = (tx_bus <= n_buses);

    // Downlink router: one frame in flight; out-of-range destinations are dropped with an error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_pend           <= 1'b0;
            data_tra_downlink <= '0;
            can_tra_select    <= 5'd0;
            tx_start          <= 32'd0;
            irq_elink_tra     <= 1'b0;
            tx_err            <= 1'b0;
        end else begin
            tx_start      <= 32'd0;
            irq_elink_tra <= 1'b0;
            tx_err        <= 1'b0;
            if (tx_offer && tx_in_range) begin
                data_tra_downlink <= tx_data;
                can_tra_select    <= tx_bus;
                tx_start          <= 32'd1 << tx_bus;
                irq_elink_tra     <= 1'b1;
                tx_pend           <= 1'b1;
            end else if (tx_offer) begin
                tx_err <= 1'b1;
            end else if (tx_pend && tx_done) begin
                tx_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mopshub_hub_ctrl_32bus.sv
// Self-checking bench for mopshub_hub_ctrl_32bus: start-up sequencing, uplink scan/capture,
// downlink routing, early exit and asynchronous reset.
module tb_mopshub_hub_ctrl_32bus;
    localparam int DATA_W       = 76;
    localparam int INIT_CYCLES  = 16;
    localparam int POWER_CYCLES = 8;
    localparam int TRIM_CYCLES  = 32;

    typedef struct packed {
        logic [4:0]        bus;
        logic [DATA_W-1:0] data;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4:0]        n_buses = 5'd0;
    logic              osc_auto_trim_mopshub = 1'b0;
    logic              endwait_all = 1'b0;
    logic [31:0]       rx_req = 32'd0;
    logic [DATA_W-1:0] rx_data;
    logic [31:0]       rx_ack;
    logic              uplink_ack = 1'b0;
    logic [DATA_W-1:0] data_rec_uplink;
    logic [4:0]        can_rec_select;
    logic              irq_elink_rec;
    logic              tx_valid = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic [4:0]        tx_bus = 5'd0;
    logic              tx_ready;
    logic [DATA_W-1:0] data_tra_downlink;
    logic [4:0]        can_tra_select;
    logic [31:0]       tx_start;
    logic              tx_done = 1'b0;
    logic              irq_elink_tra;
    logic              tx_err;
    logic              start_init, end_init, power_bus_en;
    logic [4:0]        power_bus_cnt;
    logic              start_trim_ack, end_trim_bus, end_power_init, sign_on_sig, run;

    logic [DATA_W-1:0] rx_frames [32];
    frame_t            up_q[$];
    frame_t            dn_q[$];
    logic [12:0]       st_q[$];

    int vectors = 0;
    int miscompares = 0;

    // external per-bus frame mux driven by the scan pointer
    assign rx_data = rx_frames[can_rec_select];

    wire [12:0] stat = {start_init, end_init, power_bus_en, power_bus_cnt, start_trim_ack,
                        end_trim_bus, end_power_init, sign_on_sig, run};
    wire [242:0] all_out = {rx_ack, data_rec_uplink, can_rec_select, irq_elink_rec, tx_ready,
                            data_tra_downlink, can_tra_select, tx_start, irq_elink_tra, tx_err, stat};

    mopshub_hub_ctrl_32bus #(
        .INIT_CYCLES(INIT_CYCLES), .POWER_CYCLES(POWER_CYCLES),
        .TRIM_CYCLES(TRIM_CYCLES), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .n_buses(n_buses), .osc_auto_trim_mopshub(osc_auto_trim_mopshub),
        .endwait_all(endwait_all), .rx_req(rx_req), .rx_data(rx_data), .rx_ack(rx_ack),
        .uplink_ack(uplink_ack), .data_rec_uplink(data_rec_uplink), .can_rec_select(can_rec_select),
        .irq_elink_rec(irq_elink_rec), .tx_valid(tx_valid), .tx_data(tx_data), .tx_bus(tx_bus),
        .tx_ready(tx_ready), .data_tra_downlink(data_tra_downlink), .can_tra_select(can_tra_select),
        .tx_start(tx_start), .tx_done(tx_done), .irq_elink_tra(irq_elink_tra), .tx_err(tx_err),
        .start_init(start_init), .end_init(end_init), .power_bus_en(power_bus_en),
        .power_bus_cnt(power_bus_cnt), .start_trim_ack(start_trim_ack), .end_trim_bus(end_trim_bus),
        .end_power_init(end_power_init), .sign_on_sig(sign_on_sig), .run(run)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input bit si, input bit ei, input bit en, input int bus,
                                       input bit sta, input bit eta, input bit epi, input bit son,
                                       input bit rn);
        return {si, ei, en, 5'(bus), sta, eta, epi, son, rn};
    endfunction

    // assert reset, park all inputs, release on a falling edge (next falling edge = cycle 1)
    task automatic do_reset();
        rst = 1'b1;
        rx_req = 32'd0; uplink_ack = 1'b0; endwait_all = 1'b0;
        tx_valid = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_rec(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (irq_elink_rec === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // fast start-up using endwait_all so each phase lasts one cycle
    task automatic go_run(input int n);
        int k;
        n_buses = 5'(n);
        osc_auto_trim_mopshub = 1'b0;
        do_reset();
        endwait_all = 1'b1;
        k = 0;
        while (run !== 1'b1 && k < 200) begin
            @(negedge clk);
            if (sign_on_sig === 1'b1) endwait_all = 1'b0;
            k++;
        end
        endwait_all = 1'b0;
        vectors++;
        if (run !== 1'b1) begin
            miscompares++;
            $display("FAIL reach_run: run=%b required 1 within 200 cycles", run);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_startup(input int n, input bit trim);
        logic [12:0] e;
        int cyc;
        n_buses = 5'(n);
        osc_auto_trim_mopshub = trim;
        for (int k = 0; k < INIT_CYCLES; k++)
            st_q.push_back(mk(k == 0, k == INIT_CYCLES - 1, 0, 0, 0, 0, 0, 0, 0));
        for (int b = 0; b <= n; b++) begin
            for (int p = 0; p < POWER_CYCLES; p++)
                st_q.push_back(mk(0, 0, 1, b, 0, 0, 0, 0, 0));
            if (trim)
                for (int t = 0; t < TRIM_CYCLES; t++)
                    st_q.push_back(mk(0, 0, 1, b, t == 0, t == TRIM_CYCLES - 1, 0, 0, 0));
        end
        st_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        st_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        st_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        st_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        do_reset();
        cyc = 0;
        while (st_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = st_q.pop_front();
            vectors++;
            if (stat !== e) begin
                miscompares++;
                $display("FAIL startup n=%0d trim=%0d cycle %0d: got %h required %h", n, trim, cyc, stat, e);
            end
        end
        osc_auto_trim_mopshub = 1'b0;
    endtask

    task automatic test_endwait_init();
        n_buses = 5'd3;
        do_reset();
        repeat (5) @(negedge clk);
        vectors++;
        if (end_init !== 1'b0) begin
            miscompares++;
            $display("FAIL init_no_early_end: got %b required 0", end_init);
        end
        endwait_all = 1'b1;
        tx_valid = 1'b1; tx_bus = 5'd0; tx_data = 76'h1234;
        #1;
        vectors++;
        if (end_init !== 1'b1) begin
            miscompares++;
            $display("FAIL init_endwait_end: got %b required 1", end_init);
        end
        @(negedge clk);
        endwait_all = 1'b0;
        vectors++;
        if ({power_bus_en, power_bus_cnt, end_init} !== {1'b1, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL init_to_power: got en/cnt/end %b/%0d/%b required 1/0/0",
                     power_bus_en, power_bus_cnt, end_init);
        end
        vectors++;
        if ({tx_ready, irq_elink_tra, tx_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL tx_outside_run: got ready/irq/err %b required 000", {tx_ready, irq_elink_tra, tx_err});
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_uplink();
        bit ok;
        frame_t e;
        go_run(31);
        vectors++;
        if (can_rec_select !== 5'd0) begin
            miscompares++;
            $display("FAIL run_ptr_start: got %0d required 0", can_rec_select);
        end
        rx_frames[5] = 76'hABC;
        up_q.push_back('{bus: 5'd5, data: 76'hABC});
        rx_req = 32'h20;
        wait_rec(ok);
        e = up_q.pop_front();
        vectors++;
        if (!ok || {can_rec_select, data_rec_uplink} !== {e.bus, e.data}) begin
            miscompares++;
            $display("FAIL up_capture5: got ok=%b bus %0d data %h required bus %0d data %h",
                     ok, can_rec_select, data_rec_uplink, e.bus, e.data);
        end
        vectors++;
        if (rx_ack !== 32'h20) begin
            miscompares++;
            $display("FAIL up_rx_ack5: got %h required 00000020", rx_ack);
        end
        rx_req = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({can_rec_select, irq_elink_rec, rx_ack} !== {5'd5, 1'b0, 32'd0}) begin
                miscompares++;
                $display("FAIL up_hold: got ptr %0d irq %b ack %h required 5 0 0",
                         can_rec_select, irq_elink_rec, rx_ack);
            end
        end
        uplink_ack = 1'b1;
        @(negedge clk);
        uplink_ack = 1'b0;
        vectors++;
        if (can_rec_select !== 5'd6) begin
            miscompares++;
            $display("FAIL up_resume6: got %0d required 6", can_rec_select);
        end
        @(negedge clk);
        vectors++;
        if (can_rec_select !== 5'd7) begin
            miscompares++;
            $display("FAIL up_resume7: got %0d required 7", can_rec_select);
        end
        // fill the buffer from bus 9, then release it in the same cycle bus 10 requests
        up_q.push_back('{bus: 5'd9, data: rx_frames[9]});
        rx_req = 32'd1 << 9;
        wait_rec(ok);
        e = up_q.pop_front();
        vectors++;
        if (!ok || {can_rec_select, data_rec_uplink, rx_ack} !== {e.bus, e.data, 32'd1 << 9}) begin
            miscompares++;
            $display("FAIL up_capture9: got ok=%b bus %0d data %h ack %h required bus %0d data %h",
                     ok, can_rec_select, data_rec_uplink, rx_ack, e.bus, e.data);
        end
        rx_req = 32'd1 << 10;
        uplink_ack = 1'b1;
        up_q.push_back('{bus: 5'd10, data: rx_frames[10]});
        @(negedge clk);
        uplink_ack = 1'b0;
        vectors++;
        if ({irq_elink_rec, can_rec_select} !== {1'b0, 5'd10}) begin
            miscompares++;
            $display("FAIL up_ack_same_cycle: got irq %b ptr %0d required 0 10", irq_elink_rec, can_rec_select);
        end
        @(negedge clk);
        e = up_q.pop_front();
        vectors++;
        if ({irq_elink_rec, can_rec_select, data_rec_uplink} !== {1'b1, e.bus, e.data}) begin
            miscompares++;
            $display("FAIL up_capture10_next: got irq %b bus %0d data %h required 1 %0d %h",
                     irq_elink_rec, can_rec_select, data_rec_uplink, e.bus, e.data);
        end
        rx_req = 32'd0;
        uplink_ack = 1'b1;
        @(negedge clk);
        uplink_ack = 1'b0;
    endtask

    task automatic test_priority();
        bit ok;
        frame_t e;
        int k;
        int irqs;
        int over;
        k = 0;
        while (can_rec_select !== 5'd3 && k < 64) begin
            @(negedge clk);
            k++;
        end
        rx_req = (32'd1 << 2) | (32'd1 << 30);
        up_q.push_back('{bus: 5'd30, data: rx_frames[30]});
        up_q.push_back('{bus: 5'd2, data: rx_frames[2]});
        wait_rec(ok);
        e = up_q.pop_front();
        vectors++;
        if (!ok || {can_rec_select, data_rec_uplink} !== {e.bus, e.data}) begin
            miscompares++;
            $display("FAIL prio_first: got ok=%b bus %0d data %h required bus %0d data %h",
                     ok, can_rec_select, data_rec_uplink, e.bus, e.data);
        end
        rx_req[30] = 1'b0;
        uplink_ack = 1'b1;
        @(negedge clk);
        uplink_ack = 1'b0;
        wait_rec(ok);
        e = up_q.pop_front();
        vectors++;
        if (!ok || {can_rec_select, data_rec_uplink, rx_ack} !== {e.bus, e.data, 32'd1 << 2}) begin
            miscompares++;
            $display("FAIL prio_wrap: got ok=%b bus %0d data %h ack %h required bus %0d data %h",
                     ok, can_rec_select, data_rec_uplink, rx_ack, e.bus, e.data);
        end
        rx_req = 32'd0;
        uplink_ack = 1'b1;
        @(negedge clk);
        uplink_ack = 1'b0;
        // a request above n_buses is never served
        n_buses = 5'd15;
        rx_req = 32'd1 << 30;
        irqs = 0;
        over = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (irq_elink_rec === 1'b1) irqs++;
            if (can_rec_select > 5'd15) over++;
        end
        vectors++;
        if (irqs != 0 || over != 0) begin
            miscompares++;
            $display("FAIL prio_ignore_high: got %0d captures %0d ptr>15 required 0 0", irqs, over);
        end
        rx_req = 32'd0;
        n_buses = 5'd31;
    endtask

    task automatic test_downlink();
        frame_t e;
        logic [DATA_W-1:0] d;
        @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL dn_ready_idle: got %b required 1", tx_ready);
        end
        d = {12'h4C4, 32'($urandom), 32'($urandom)};
        tx_valid = 1'b1; tx_bus = 5'd4; tx_data = d;
        dn_q.push_back('{bus: 5'd4, data: d});
        @(negedge clk);
        tx_valid = 1'b0;
        e = dn_q.pop_front();
        vectors++;
        if ({can_tra_select, data_tra_downlink} !== {e.bus, e.data}) begin
            miscompares++;
            $display("FAIL dn_latch4: got bus %0d data %h required %0d %h",
                     can_tra_select, data_tra_downlink, e.bus, e.data);
        end
        vectors++;
        if ({tx_start, irq_elink_tra, tx_ready} !== {32'h10, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL dn_start4: got start %h irq %b ready %b required 00000010 1 0",
                     tx_start, irq_elink_tra, tx_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({tx_start, irq_elink_tra, tx_ready} !== {32'd0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL dn_pending: got start %h irq %b ready %b required 0 0 0",
                         tx_start, irq_elink_tra, tx_ready);
            end
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL dn_ready_after_done: got %b required 1", tx_ready);
        end
        // accept a frame for bus 7, then offer another in the same cycle as tx_done
        d = {12'h777, 32'($urandom), 32'($urandom)};
        tx_valid = 1'b1; tx_bus = 5'd7; tx_data = d;
        dn_q.push_back('{bus: 5'd7, data: d});
        @(negedge clk);
        e = dn_q.pop_front();
        vectors++;
        if ({irq_elink_tra, tx_start, can_tra_select, data_tra_downlink} !== {1'b1, 32'd1 << 7, e.bus, e.data}) begin
            miscompares++;
            $display("FAIL dn_accept7: got irq %b start %h bus %0d data %h required 1 %h %0d %h",
                     irq_elink_tra, tx_start, can_tra_select, data_tra_downlink, 32'd1 << 7, e.bus, e.data);
        end
        d = {12'hC0C, 32'($urandom), 32'($urandom)};
        tx_bus = 5'd12; tx_data = d; tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        vectors++;
        if ({irq_elink_tra, tx_ready, can_tra_select} !== {1'b0, 1'b1, 5'd7}) begin
            miscompares++;
            $display("FAIL dn_done_and_valid: got irq %b ready %b bus %0d required 0 1 7",
                     irq_elink_tra, tx_ready, can_tra_select);
        end
        dn_q.push_back('{bus: 5'd12, data: d});
        @(negedge clk);
        tx_valid = 1'b0;
        e = dn_q.pop_front();
        vectors++;
        if ({irq_elink_tra, tx_start, can_tra_select, data_tra_downlink} !== {1'b1, 32'd1 << 12, e.bus, e.data}) begin
            miscompares++;
            $display("FAIL dn_accept12: got irq %b start %h bus %0d data %h required 1 %h %0d %h",
                     irq_elink_tra, tx_start, can_tra_select, data_tra_downlink, 32'd1 << 12, e.bus, e.data);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        // out-of-range destination: error pulse, nothing latched
        n_buses = 5'd15;
        tx_valid = 1'b1; tx_bus = 5'd20; tx_data = {DATA_W{1'b1}};
        @(negedge clk);
        tx_valid = 1'b0;
        vectors++;
        if ({tx_err, irq_elink_tra, tx_start, tx_ready} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL dn_err20: got err %b irq %b start %h ready %b required 1 0 0 1",
                     tx_err, irq_elink_tra, tx_start, tx_ready);
        end
        vectors++;
        if ({can_tra_select, data_tra_downlink} !== {5'd12, d}) begin
            miscompares++;
            $display("FAIL dn_err_no_latch: got bus %0d data %h required 12 %h",
                     can_tra_select, data_tra_downlink, d);
        end
        @(negedge clk);
        vectors++;
        if (tx_err !== 1'b0) begin
            miscompares++;
            $display("FAIL dn_err_pulse_width: got %b required 0", tx_err);
        end
        n_buses = 5'd31;
    endtask

    task automatic test_reset_in_run();
        bit ok;
        frame_t e;
        go_run(31);
        up_q.push_back('{bus: 5'd5, data: rx_frames[5]});
        rx_req = 32'h20;
        wait_rec(ok);
        e = up_q.pop_front();
        vectors++;
        if (!ok || {can_rec_select, data_rec_uplink} !== {e.bus, e.data}) begin
            miscompares++;
            $display("FAIL rr_capture: got ok=%b bus %0d data %h required %0d %h",
                     ok, can_rec_select, data_rec_uplink, e.bus, e.data);
        end
        rx_req = 32'd0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL rr_async_clear: got %h required 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({start_init, run, power_bus_en} !== 3'b100) begin
            miscompares++;
            $display("FAIL rr_restart: got start_init/run/en %b required 100", {start_init, run, power_bus_en});
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            rx_frames[i] = {12'(i), 32'($urandom), 32'($urandom)};
        test_reset();
        test_startup(3, 1'b0);
        test_startup(1, 1'b1);
        test_endwait_init();
        test_uplink();
        test_priority();
        test_downlink();
        test_reset_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end
endmodule
